// File: rtl/conv_latency_meter.sv
// Convergence-latency meter: times how many gamma cycles a layer needs to settle
// after each input transition and queues the results in a 4-entry record FIFO.
// Optional feature macro: CLM_PEAK_ERR_EN (per-record peak error capture).
module conv_latency_meter #(
  parameter logic [7:0] TOL     = 8'd5,
  parameter logic [2:0] STABLE  = 3'd1,
  parameter logic [7:0] MAX_CYC = 8'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cycle_start,
  input  logic [7:0] error,
  input  logic       trans_start,
  input  logic [2:0] trans_tag,
  output logic       busy,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [2:0] rd_tag,
  output logic [1:0] rd_status,
  output logic [7:0] rd_latency,
  output logic [7:0] rd_peak,
  output logic [7:0] drop_cnt
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

`ifdef CLM_PEAK_ERR_EN
  localparam int REC_W = 21;
`else
  localparam int REC_W = 13;
`endif

  state_t     state_r, state_s;
  logic [2:0] tag_r, tag_s;
  logic [7:0] cyc_cnt_r, cyc_cnt_s;
  logic [2:0] run_cnt_r, run_cnt_s;
  logic [7:0] run_start_r, run_start_s;

  logic [7:0] cyc_inc_s;
  logic [2:0] run_inc_s;
  logic [7:0] run_start_new_s;
  logic       err_ok_s;

  logic       push_s;
  logic [2:0] push_tag_s;
  logic [1:0] push_status_s;
  logic [7:0] push_lat_s;
  logic [REC_W-1:0] push_rec_s;

`ifdef CLM_PEAK_ERR_EN
  logic [7:0] peak_r, peak_s, peak_upd_s, push_peak_s;
  assign peak_upd_s = (error > peak_r) ? error : peak_r;
  assign push_rec_s = {push_tag_s, push_status_s, push_lat_s, push_peak_s};
`else
  assign push_rec_s = {push_tag_s, push_status_s, push_lat_s};
`endif

  assign cyc_inc_s       = cyc_cnt_r + 8'd1;
  assign err_ok_s        = (error <= TOL);
  assign run_inc_s       = (run_cnt_r == 3'd7) ? 3'd7 : run_cnt_r + 3'd1;
  // A run opening on this boundary starts at the cycle being counted now.
  assign run_start_new_s = (run_cnt_r == 3'd0) ? cyc_inc_s : run_start_r;

  // Measurement state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      tag_r       <= 3'd0;
      cyc_cnt_r   <= 8'd0;
      run_cnt_r   <= 3'd0;
      run_start_r <= 8'd0;
`ifdef CLM_PEAK_ERR_EN
      peak_r      <= 8'd0;
`endif
    end else begin
      state_r     <= state_s;
      tag_r       <= tag_s;
      cyc_cnt_r   <= cyc_cnt_s;
      run_cnt_r   <= run_cnt_s;
      run_start_r <= run_start_s;
`ifdef CLM_PEAK_ERR_EN
      peak_r      <= peak_s;
`endif
    end
  end

  // Next-state logic and record generation; trans_start has priority over cycle_start.
  always_comb begin
    state_s       = state_r;
    tag_s         = tag_r;
    cyc_cnt_s     = cyc_cnt_r;
    run_cnt_s     = run_cnt_r;
    run_start_s   = run_start_r;
    push_s        = 1'b0;
    push_tag_s    = tag_r;
    push_status_s = 2'b00;
    push_lat_s    = 8'd0;
`ifdef CLM_PEAK_ERR_EN
    peak_s        = peak_r;
    push_peak_s   = peak_r;
`endif
    case (state_r)
      IDLE: begin
        if (trans_start) begin
          state_s     = MEASURE;
          tag_s       = trans_tag;
          cyc_cnt_s   = 8'd0;
          run_cnt_s   = 3'd0;
          run_start_s = 8'd0;
`ifdef CLM_PEAK_ERR_EN
          peak_s      = 8'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      MEASURE: begin
        if (trans_start) begin
          push_s        = 1'b1;
          push_status_s = 2'b10;
          push_lat_s    = cyc_cnt_r;
          tag_s         = trans_tag;
          cyc_cnt_s     = 8'd0;
          run_cnt_s     = 3'd0;
          run_start_s   = 8'd0;
`ifdef CLM_PEAK_ERR_EN
          peak_s        = 8'd0;
`endif
        end else if (cycle_start) begin
          cyc_cnt_s = cyc_inc_s;
`ifdef CLM_PEAK_ERR_EN
          peak_s      = peak_upd_s;
          push_peak_s = peak_upd_s;
`endif
          if (err_ok_s) begin
            run_cnt_s   = run_inc_s;
            run_start_s = run_start_new_s;
          end else begin
            run_cnt_s   = 3'd0;
            run_start_s = run_start_r;
          end
          if (err_ok_s && (run_inc_s >= STABLE)) begin
            push_s        = 1'b1;
            push_status_s = 2'b00;
            push_lat_s    = run_start_new_s;
            state_s       = IDLE;
          end else if (cyc_inc_s >= MAX_CYC) begin
            push_s        = 1'b1;
            push_status_s = 2'b01;
            push_lat_s    = MAX_CYC;
            state_s       = IDLE;
          end else begin
            state_s = MEASURE;
          end
        end else begin
          state_s = MEASURE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Record FIFO with a registered head stage.
  logic [REC_W-1:0] mem_r [4];
  logic [REC_W-1:0] rd_rec_r;
  logic [1:0]       wr_ptr_r, rd_ptr_r, head_ptr_s;
  logic [2:0]       count_r, left_s;
  logic             rd_valid_r, pop_s, full_s, wr_en_s, drop_s;
  logic [7:0]       drop_cnt_r;

  assign pop_s      = rd_valid_r & rd_ready & (count_r != 3'd0);
  assign full_s     = (count_r == 3'd4);
  assign wr_en_s    = push_s & (~full_s | pop_s);
  assign drop_s     = push_s & full_s & ~pop_s;
  assign left_s     = count_r - {2'b00, pop_s};
  assign head_ptr_s = pop_s ? (rd_ptr_r + 2'd1) : rd_ptr_r;

  // FIFO storage, pointers, drop counter and head register; a push becomes visible one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_r[i] <= {REC_W{1'b0}};
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      count_r    <= 3'd0;
      drop_cnt_r <= 8'd0;
      rd_valid_r <= 1'b0;
      rd_rec_r   <= {REC_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_rec_s;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      count_r <= count_r + {2'b00, wr_en_s} - {2'b00, pop_s};
      if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'd1;
      rd_valid_r <= (left_s != 3'd0);
      rd_rec_r   <= (left_s != 3'd0) ? mem_r[head_ptr_s] : {REC_W{1'b0}};
    end
  end

  assign busy       = (state_r == MEASURE);
  assign rd_valid   = rd_valid_r;
  assign rd_tag     = rd_rec_r[REC_W-1 -: 3];
  assign rd_status  = rd_rec_r[REC_W-4 -: 2];
  assign rd_latency = rd_rec_r[REC_W-6 -: 8];
  assign drop_cnt   = drop_cnt_r;
`ifdef CLM_PEAK_ERR_EN
  assign rd_peak    = rd_rec_r[7:0];
`else
  assign rd_peak    = 8'd0;
`endif

endmodule

// File: tb/tb_conv_latency_meter.sv
// Directed bench for conv_latency_meter with a scoreboard of expected records.
module tb_conv_latency_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cs = 1'b0, ts = 1'b0, rdy = 1'b0;
  logic [7:0] err = 8'd0;
  logic [2:0] tg = 3'd0;
  logic       busy, rv, cs2 = 1'b0, ts2 = 1'b0, rdy2 = 1'b0;
  logic [2:0] rtag;
  logic [1:0] rst_s;
  logic [7:0] rlat, rpk, dcnt;
  logic [7:0] err2 = 8'd0;
  logic [2:0] tg2 = 3'd0;
  logic       busy2, rv2;
  logic [2:0] rtag2;
  logic [1:0] rst_s2;
  logic [7:0] rlat2, rpk2, dcnt2;

  conv_latency_meter dut (
    .clk(clk), .rst(rst), .cycle_start(cs), .error(err), .trans_start(ts), .trans_tag(tg),
    .busy(busy), .rd_valid(rv), .rd_ready(rdy), .rd_tag(rtag), .rd_status(rst_s),
    .rd_latency(rlat), .rd_peak(rpk), .drop_cnt(dcnt));

  conv_latency_meter #(.STABLE(3'd2)) dut2 (
    .clk(clk), .rst(rst), .cycle_start(cs2), .error(err2), .trans_start(ts2), .trans_tag(tg2),
    .busy(busy2), .rd_valid(rv2), .rd_ready(rdy2), .rd_tag(rtag2), .rd_status(rst_s2),
    .rd_latency(rlat2), .rd_peak(rpk2), .drop_cnt(dcnt2));

`ifdef CLM_PEAK_ERR_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  typedef struct packed {logic [2:0] tag; logic [1:0] st; logic [7:0] lat; logic [7:0] pk;} rec_t;
  rec_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rec(input logic [2:0] t, input logic [1:0] s, input logic [7:0] l, input logic [7:0] p);
    rec_t r;
    r.tag = t; r.st = s; r.lat = l; r.pk = PK ? p : 8'd0;
    sb.push_back(r);
  endtask

  task automatic trans(input logic [2:0] t);
    ts = 1'b1; tg = t; tick(); ts = 1'b0;
  endtask

  task automatic bnd(input logic [7:0] e);
    cs = 1'b1; err = e; tick(); cs = 1'b0;
  endtask

  task automatic bnd2(input logic [7:0] e);
    cs2 = 1'b1; err2 = e; tick(); cs2 = 1'b0;
  endtask

  // Wait (bounded) for a record on the selected DUT, compare against the scoreboard head, then pop it.
  task automatic drain(input bit sel, input string name);
    rec_t e;
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if ((sel ? rv2 : rv) === 1'b1) got = 1'b1;
      else tick();
    end
    check({name, "_valid"}, {31'd0, got}, 32'd1);
    check({name, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      check({name, "_tag"},    {29'd0, sel ? rtag2 : rtag},   {29'd0, e.tag});
      check({name, "_status"}, {30'd0, sel ? rst_s2 : rst_s}, {30'd0, e.st});
      check({name, "_lat"},    {24'd0, sel ? rlat2 : rlat},   {24'd0, e.lat});
      check({name, "_peak"},   {24'd0, sel ? rpk2 : rpk},     {24'd0, e.pk});
      if (sel) rdy2 = 1'b1; else rdy = 1'b1;
      tick();
      rdy = 1'b0; rdy2 = 1'b0;
    end
  endtask

  initial begin
    // Reset held for 3 clks
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, rv}, 32'd0);
    check("rst_tag", {29'd0, rtag}, 32'd0);
    check("rst_status", {30'd0, rst_s}, 32'd0);
    check("rst_lat", {24'd0, rlat}, 32'd0);
    check("rst_peak", {24'd0, rpk}, 32'd0);
    check("rst_drop", {24'd0, dcnt}, 32'd0);
    check("rst_valid2", {31'd0, rv2}, 32'd0);

    // Basic convergence: 40, 20, 4 -> latency 3
    trans(3'd3);
    check("busy_after_trans", {31'd0, busy}, 32'd1);
    tick(); tick();
    check("no_rec_without_boundary", {31'd0, rv}, 32'd0);
    bnd(8'd40); bnd(8'd20); bnd(8'd4);
    expect_rec(3'd3, 2'b00, 8'd3, 8'd40);
    check("valid_lags_push", {31'd0, rv}, 32'd0);
    check("busy_falls_conv", {31'd0, busy}, 32'd0);
    drain(1'b0, "conv3");

    // Timeout after MAX_CYC boundaries
    trans(3'd5);
    for (int i = 0; i < 9; i++) bnd(8'd30);
    check("busy_before_timeout", {31'd0, busy}, 32'd1);
    bnd(8'd30);
    expect_rec(3'd5, 2'b01, 8'd10, 8'd30);
    check("busy_falls_timeout", {31'd0, busy}, 32'd0);
    drain(1'b0, "timeout");

    // Abort by new transition, then the new measurement converges
    trans(3'd1);
    bnd(8'd50); bnd(8'd50);
    trans(3'd2);
    expect_rec(3'd1, 2'b10, 8'd2, 8'd50);
    check("busy_after_abort", {31'd0, busy}, 32'd1);
    bnd(8'd5);
    expect_rec(3'd2, 2'b00, 8'd1, 8'd5);
    drain(1'b0, "abort");
    drain(1'b0, "after_abort");

    // trans_start with simultaneous cycle_start: that boundary is not sampled
    cs = 1'b1; err = 8'd200; trans(3'd6); cs = 1'b0;
    bnd(8'd2);
    expect_rec(3'd6, 2'b00, 8'd1, 8'd2);
    drain(1'b0, "same_clk");

    // STABLE=2 instance: 4, 9, 5, 2 -> latency 3
    ts2 = 1'b1; tg2 = 3'd4; tick(); ts2 = 1'b0;
    bnd2(8'd4); bnd2(8'd9); bnd2(8'd5);
    check("stable2_busy", {31'd0, busy2}, 32'd1);
    bnd2(8'd2);
    expect_rec(3'd4, 2'b00, 8'd3, 8'd9);
    drain(1'b1, "stable2");

    // Overflow: six records with rd_ready low, only the first four kept
    for (int t = 0; t < 6; t++) begin
      trans(3'(t));
      bnd(8'd0);
      if (t < 4) expect_rec(3'(t), 2'b00, 8'd1, 8'd0);
    end
    tick();
    check("drop_cnt", {24'd0, dcnt}, 32'd2);
    tick(); tick();
    check("hold_valid", {31'd0, rv}, 32'd1);
    check("hold_tag", {29'd0, rtag}, 32'd0);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rec_t e;
      e = sb.pop_front();
      check("burst_valid", {31'd0, rv}, 32'd1);
      check("burst_tag", {29'd0, rtag}, {29'd0, e.tag});
      tick();
    end
    check("burst_empty", {31'd0, rv}, 32'd0);
    tick();
    check("pop_empty_ignored", {31'd0, rv}, 32'd0);
    rdy = 1'b0;

    // Reset mid-measurement with a queued record
    trans(3'd7); bnd(8'd1);
    trans(3'd2); bnd(8'd60);
    tick();
    check("pre_reset_valid", {31'd0, rv}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_valid", {31'd0, rv}, 32'd0);
    check("async_rst_drop", {24'd0, dcnt}, 32'd0);
    tick();
    rst = 1'b0;
    bnd(8'd0);
    tick();
    check("post_rst_no_rec", {31'd0, rv}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
